// File: rtl/led_trace_monitor.sv
// led_trace_monitor: holds the core in reset for RST_HOLD cycles, then timestamps
// every status-bus change into a drainable FIFO and flags pass, watchdog timeout and overflow.
module led_trace_monitor #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   parameter int TS_W = 16,
   parameter int RST_HOLD = 4,
   parameter int TIMEOUT = 1000,
   parameter logic [WIDTH-1:0] PASS_VALUE = {WIDTH{1'b1}}
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  dut_rst_n,
   input  logic [WIDTH-1:0]      status_in,
   output logic                  ev_valid,
   input  logic                  ev_ready,
   output logic [TS_W+WIDTH-1:0] ev_data,
   output logic                  overflow,
   output logic                  timeout,
   output logic                  pass,
   output logic [TS_W-1:0]       cycle_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int HW = RST_HOLD > 1 ? $clog2(RST_HOLD) : 1;
   localparam int IW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam int EW = TS_W + WIDTH;

   typedef enum logic [1:0] {HOLD, RUN, DONE, TOUT} state_t;

   state_t            state, state_d;
   logic [HW-1:0]     hold_cnt;
   logic [IW-1:0]     idle_cnt;
   logic [WIDTH-1:0]  prev_status;
   logic              first;
   logic [EW-1:0]     mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic              running, hold_done, push, is_pass, expire;
   logic              empty, full, pop, do_write, drop;

   always_comb begin
      running   = state == RUN;
      hold_done = state == HOLD && hold_cnt == HW'(RST_HOLD - 1);
      push      = running && (first || status_in != prev_status);
      is_pass   = running && status_in == PASS_VALUE;
      expire    = running && TIMEOUT != 0 && !push &&
                  ({1'b0, idle_cnt} + 1'b1) == (IW + 1)'(TIMEOUT);
      empty     = wr_ptr == rd_ptr;
      full      = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
      pop       = !empty && ev_ready;
      do_write  = push && (!full || pop);
      drop      = push && full && !pop;
      state_d   = hold_done ? RUN : is_pass ? DONE : expire ? TOUT : state;
      ev_valid  = !empty;
      ev_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= HOLD;
         dut_rst_n   <= 1'b0;
         hold_cnt    <= '0;
         idle_cnt    <= '0;
         prev_status <= '0;
         first       <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         overflow    <= 1'b0;
         timeout     <= 1'b0;
         pass        <= 1'b0;
         cycle_count <= '0;
      end else begin
         state     <= state_d;
         first     <= hold_done;
         dut_rst_n <= dut_rst_n | hold_done;
         if (state == HOLD)
            hold_cnt <= hold_cnt + 1'b1;
         if (running) begin
            prev_status <= status_in;
            idle_cnt    <= push ? '0 : idle_cnt != '1 ? idle_cnt + 1'b1 : idle_cnt;
         end
         // The count freezes on the edge that leaves RUN so it matches the final event stamp.
         if (running && state_d == RUN && cycle_count != '1)
            cycle_count <= cycle_count + 1'b1;
         if (do_write)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         overflow <= overflow | drop;
         pass     <= pass | is_pass;
         timeout  <= timeout | (expire && !is_pass);
      end
   end

   always_ff @(posedge clk)
      if (do_write)
         mem[wr_ptr[AW-1:0]] <= {cycle_count, status_in};
endmodule

// File: tb/tb_led_trace_monitor.sv
// tb_led_trace_monitor: directed checks of hold release, change capture, overflow,
// pass, watchdog and mid-run reset; a second instance has the watchdog disabled.
module tb_led_trace_monitor;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  status_in = '0;
   logic        ev_ready = 1'b0;
   logic        dut_rst_n, ev_valid, overflow, timeout, pass;
   logic [19:0] ev_data;
   logic [15:0] cycle_count;
   logic        n_dut_rst_n, n_ev_valid, n_overflow, n_timeout, n_pass;
   logic [19:0] n_ev_data;
   logic [15:0] n_cycle_count;
   int checks = 0;
   int errors = 0;
   int e = 0;

   always #5 clk = ~clk;

   led_trace_monitor #(.TIMEOUT(10)) u_dut (
      .clk(clk), .rst(rst), .dut_rst_n(dut_rst_n), .status_in(status_in),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
      .overflow(overflow), .timeout(timeout), .pass(pass), .cycle_count(cycle_count)
   );

   led_trace_monitor #(.TIMEOUT(0)) u_nowd (
      .clk(clk), .rst(rst), .dut_rst_n(n_dut_rst_n), .status_in(status_in),
      .ev_valid(n_ev_valid), .ev_ready(ev_ready), .ev_data(n_ev_data),
      .overflow(n_overflow), .timeout(n_timeout), .pass(n_pass), .cycle_count(n_cycle_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ev(input int t, input int s);
      return 32'((t << 4) | s);
   endfunction

   // RUN cycle k is sampled at edge 5+k after rst goes high (RST_HOLD=4).
   task automatic go(input int k);
      repeat (5 + k - e) @(posedge clk);
      e = 5 + k;
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      chk("rst_dut_rst_n", 32'(dut_rst_n), 0);
      chk("rst_ev_valid", 32'(ev_valid), 0);
      chk("rst_ev_data", 32'(ev_data), 0);
      chk("rst_flags", {29'd0, overflow, timeout, pass}, 0);
      chk("rst_cycle_count", 32'(cycle_count), 0);
      rst = 1'b1;
      e = 0;
   endtask

   initial begin
      // Run 1: hold release, baseline, change capture, pass.
      status_in = 'x;
      do_reset(3);
      go(-2);
      chk("hold_edge3", 32'(dut_rst_n), 0);
      go(-1);
      chk("hold_edge4", 32'(dut_rst_n), 1);
      chk("hold_no_event", 32'(ev_valid), 0);
      status_in = 4'h0;
      go(0);
      chk("baseline_valid", 32'(ev_valid), 1);
      chk("baseline_data", 32'(ev_data), ev(0, 0));
      chk("count_after_c0", 32'(cycle_count), 1);
      ev_ready = 1'b1;
      go(4);
      status_in = 4'h1;
      go(5);
      chk("chg1_data", 32'(ev_data), ev(5, 1));
      go(7);
      chk("const_no_event", 32'(ev_valid), 0);
      go(8);
      status_in = 4'h3;
      go(9);
      chk("chg2_data", 32'(ev_data), ev(9, 3));
      go(14);
      status_in = 4'h2;
      go(15);
      chk("chg3_data", 32'(ev_data), ev(15, 2));
      go(19);
      status_in = 4'hF;
      go(20);
      chk("pass_data", 32'(ev_data), ev(20, 15));
      chk("pass_flag", 32'(pass), 1);
      chk("pass_count", 32'(cycle_count), 20);
      status_in = 4'h5;
      go(22);
      status_in = 4'h6;
      go(25);
      chk("done_no_event", 32'(ev_valid), 0);
      chk("done_count_frozen", 32'(cycle_count), 20);
      chk("done_timeout", 32'(timeout), 0);
      chk("done_rst_n", 32'(dut_rst_n), 1);

      // Run 2: overflow, full push+pop, drain order, watchdog.
      ev_ready = 1'b0;
      status_in = 4'h0;
      do_reset(2);
      for (int k = 1; k <= 8; k++) begin
         go(k - 1);
         status_in = 4'(k % 2);
      end
      chk("ovf_not_yet", 32'(overflow), 0);
      go(8);
      chk("ovf_set", 32'(overflow), 1);
      status_in = 4'h1;
      go(9);
      status_in = 4'h0;
      go(10);
      chk("full_head", 32'(ev_data), ev(0, 0));
      ev_ready = 1'b1;
      status_in = 4'h5;
      for (int j = 1; j <= 7; j++) begin
         go(10 + j);
         chk($sformatf("drain_%0d", j), 32'(ev_data), ev(j, j % 2));
      end
      go(18);
      chk("drain_pushpop", 32'(ev_data), ev(11, 5));
      go(19);
      chk("drain_empty", 32'(ev_valid), 0);
      go(20);
      chk("wd_not_yet", 32'(timeout), 0);
      go(21);
      chk("wd_expired", 32'(timeout), 1);
      chk("wd_disabled", 32'(n_timeout), 0);
      go(23);
      chk("tout_count_frozen", 32'(cycle_count), 21);
      chk("nowd_count_runs", 32'(n_cycle_count), 24);
      chk("tout_pass", 32'(pass), 0);

      // Run 3: pass on the watchdog expiry cycle.
      ev_ready = 1'b0;
      status_in = 4'h0;
      do_reset(2);
      go(9);
      chk("pre_expiry_timeout", 32'(timeout), 0);
      status_in = 4'hF;
      go(10);
      chk("expiry_pass", 32'(pass), 1);
      chk("expiry_timeout", 32'(timeout), 0);
      go(12);
      chk("expiry_timeout_late", 32'(timeout), 0);

      // Run 4: mid-run reset with queued events.
      status_in = 4'h0;
      do_reset(2);
      go(0);
      status_in = 4'h1;
      go(1);
      status_in = 4'h2;
      go(2);
      chk("queued_valid", 32'(ev_valid), 1);
      chk("queued_head", 32'(ev_data), ev(0, 0));
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_ev_valid", 32'(ev_valid), 0);
      chk("mid_ev_data", 32'(ev_data), 0);
      chk("mid_dut_rst_n", 32'(dut_rst_n), 0);
      chk("mid_flags", {29'd0, overflow, timeout, pass}, 0);
      chk("mid_count", 32'(cycle_count), 0);
      rst = 1'b1;
      e = 0;
      go(-2);
      chk("rehold_edge3", 32'(dut_rst_n), 0);
      go(-1);
      chk("rehold_edge4", 32'(dut_rst_n), 1);
      chk("rehold_empty", 32'(ev_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
